// File: rtl/vc_test_rr_arbiter.sv
// Round-robin arbiter merging p_nreqs val/rdy streams into one val/rdy stream
// through a one-entry output register tagged with the winning requester index.
module vc_test_rr_arbiter #(
  parameter int p_msg_nbits = 8,
  parameter int p_nreqs     = 4,
  parameter int p_src_nbits = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             in_val,
  output logic [p_nreqs-1:0]             in_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_nbits-1:0]         out_msg,
  output logic [p_src_nbits-1:0]         out_src,
  output logic [31:0]                    count
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  localparam logic [p_src_nbits-1:0] SRC_LAST = p_src_nbits'(p_nreqs - 1);
  localparam logic [p_src_nbits-1:0] SRC_ONE  = p_src_nbits'(1);

  state_t                   state_reg, state_next;
  logic [p_src_nbits-1:0]   ptr_reg, ptr_next;
  logic [p_msg_nbits-1:0]   msg_reg, msg_next;
  logic [p_src_nbits-1:0]   src_reg, src_next;
  logic [31:0]              count_reg, count_next;

  logic [p_msg_nbits-1:0]   msg_arr [p_nreqs];
  logic [p_nreqs-1:0]       ptr_mask;
  logic [p_nreqs-1:0]       req_hi;
  logic                     hi_found, lo_found;
  logic [p_src_nbits-1:0]   hi_idx, lo_idx, grant_idx;
  logic                     can_accept, grant_fire;
  logic [p_msg_nbits-1:0]   sel_msg;

  // Requesters at or above the pointer win over those that wrapped around.
  genvar gi;
  generate
    for (gi = 0; gi < p_nreqs; gi++) begin : g_req
      assign msg_arr[gi]  = in_msg[gi*p_msg_nbits +: p_msg_nbits];
      assign ptr_mask[gi] = (p_src_nbits'(gi) >= ptr_reg);
      assign req_hi[gi]   = in_val[gi] & ptr_mask[gi];
      assign in_rdy[gi]   = grant_fire && (grant_idx == p_src_nbits'(gi));
    end
  endgenerate

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = p_nreqs - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        hi_found = 1'b1;
        hi_idx   = p_src_nbits'(i);
      end
      if (in_val[i]) begin
        lo_found = 1'b1;
        lo_idx   = p_src_nbits'(i);
      end
    end
  end

  assign grant_idx  = hi_found ? hi_idx : lo_idx;
  assign can_accept = (state_reg == ST_EMPTY) || out_rdy;
  // Reset gates the grant so nothing is consumed while the block is held in reset.
  assign grant_fire = reset && can_accept && lo_found;

  // One-hot AND-OR mux keeps the message select independent of index width.
  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      sel_msg = sel_msg | ({p_msg_nbits{in_rdy[i]}} & msg_arr[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    msg_next   = msg_reg;
    src_next   = src_reg;
    count_next = count_reg;
    case (state_reg)
      ST_EMPTY: if (grant_fire) state_next = ST_FULL;
      ST_FULL:  if (out_rdy && !grant_fire) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
    if (grant_fire) begin
      msg_next   = sel_msg;
      src_next   = grant_idx;
      ptr_next   = (grant_idx == SRC_LAST) ? '0 : grant_idx + SRC_ONE;
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_EMPTY;
      ptr_reg   <= '0;
      msg_reg   <= '0;
      src_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      msg_reg   <= msg_next;
      src_reg   <= src_next;
      count_reg <= count_next;
    end
  end

  assign out_val = (state_reg == ST_FULL);
  assign out_msg = msg_reg;
  assign out_src = src_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_vc_test_rr_arbiter.sv
// Scoreboard bench for vc_test_rr_arbiter: 4-requester instance with a
// reference round-robin model, plus a 3-requester instance for wrap checks.
module tb_vc_test_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     in_val, in_rdy;
  logic [N*W-1:0]   in_msg;
  logic             out_val, out_rdy;
  logic [W-1:0]     out_msg;
  logic [S-1:0]     out_src;
  logic [31:0]      count;

  vc_test_rr_arbiter #(.p_msg_nbits(W), .p_nreqs(N), .p_src_nbits(S)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src),
    .count(count)
  );

  logic             reset3;
  logic [2:0]       in_val3, in_rdy3;
  logic [3*W-1:0]   in_msg3;
  logic             out_val3, out_rdy3;
  logic [W-1:0]     out_msg3;
  logic [S-1:0]     out_src3;
  logic [31:0]      count3;

  vc_test_rr_arbiter #(.p_msg_nbits(W), .p_nreqs(3), .p_src_nbits(S)) dut3 (
    .clk(clk), .reset(reset3), .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
    .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3), .out_src(out_src3),
    .count(count3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int       src;
    logic [W-1:0] msg;
  } item_t;

  item_t        sb_q[$];
  int           src_log[$];
  bit           model_valid = 1'b0;
  int           mptr = 0;
  int           mcount = 0;
  logic [N-1:0] xfer_mask = '0;

  logic [W-1:0] mem [N][DEPTH];
  int           head [N];
  int           tail [N];
  int           dly  [N];
  int           maxd [N];
  bit           force_all;
  bit           n3_done = 1'b0;

  // Reference model: decides the expected grant, checks outputs, then applies the edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           g;
    int           idx;
    item_t        it;
    exp_rdy = '0;
    g = -1;
    if (reset === 1'b1 && model_valid && (sb_q.size() == 0 || out_rdy === 1'b1)) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && in_val[idx] === 1'b1) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("in_rdy", in_rdy, exp_rdy);
    if (model_valid && reset === 1'b1) begin
      check_val("out_val", out_val, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
        check_val("out_src", out_src, sb_q[0].src);
        check_val("out_msg", out_msg, sb_q[0].msg);
      end
      check_val("count", count, mcount);
    end
    xfer_mask = exp_rdy & in_val;
    if (reset === 1'b0) begin
      sb_q.delete();
      mptr = 0;
      mcount = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (sb_q.size() != 0 && out_rdy === 1'b1) begin
        it = sb_q.pop_front();
        src_log.push_back(it.src);
        $display("out xfer src=%0d msg=%02h count=%0d", it.src, it.msg, mcount);
      end
      if (g >= 0) begin
        it.src = g;
        it.msg = in_msg[g*W +: W];
        sb_q.push_back(it);
        mptr = (g + 1) % N;
        mcount++;
      end
    end
  end

  task automatic enq(input int i, input logic [W-1:0] m);
    mem[i][tail[i]] = m;
    tail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_val[i] = force_all || (head[i] != tail[i] && dly[i] == 0);
      in_msg[i*W +: W] = (head[i] != tail[i]) ? mem[i][head[i]] : '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer_mask[i] && head[i] != tail[i]) begin
        head[i]++;
        dly[i] = int'($urandom_range(maxd[i], 0));
      end else if (dly[i] > 0) begin
        dly[i]--;
      end
    end
    drive();
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (sb_q.size() == 0);
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) idle = 1'b0;
    return idle;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    int          c0;
    logic [W-1:0] m0;
    logic [S-1:0] s0;
    int          cnt [N];
    bit          done;

    reset = 1'b0;
    out_rdy = 1'b0;
    force_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; dly[i] = 0; maxd[i] = 0;
    end
    drive();

    // Reset with every requester asserting val, then release idle.
    step();
    step();
    reset = 1'b1;
    force_all = 1'b0;
    drive();
    step();
    check_val("t1_out_val", out_val, 1'b0);
    check_val("t1_count", count, 0);

    // Single requester streaming back-to-back.
    src_log.delete();
    enq(2, 8'h11); enq(2, 8'h22); enq(2, 8'h33);
    out_rdy = 1'b1;
    drive();
    repeat (6) step();
    check_val("t2_nout", src_log.size(), 3);
    for (int j = 0; j < src_log.size(); j++) check_val("t2_src", src_log[j], 2);
    check_val("t2_count", count, 3);

    // Full contention from a fresh pointer.
    do_reset();
    src_log.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) enq(i, 8'(8'h10 * i + k));
    drive();
    repeat (12) step();
    check_val("t3_nout", src_log.size(), 8);
    for (int j = 0; j < src_log.size(); j++) check_val("t3_order", src_log[j], j % 4);

    // Backpressure with the register full and all requesters waiting.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) enq(i, 8'(8'h40 + 8'h10 * i + k));
    out_rdy = 1'b0;
    drive();
    step();
    c0 = int'(count);
    m0 = out_msg;
    s0 = out_src;
    repeat (5) step();
    check_val("t4_count_hold", count, c0);
    check_val("t4_msg_hold", out_msg, m0);
    check_val("t4_src_hold", out_src, s0);
    check_val("t4_val_hold", out_val, 1'b1);
    src_log.delete();
    out_rdy = 1'b1;
    repeat (14) step();
    check_val("t4_nout", src_log.size(), 12);
    for (int j = 0; j < src_log.size(); j++) check_val("t4_order", src_log[j], j % 4);

    // Mid-run reset while full with the pointer at 3.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) enq(i, 8'(8'h80 + 8'h10 * i + k));
    drive();
    for (int b = 0; b < 20 && !(mptr == 3 && sb_q.size() == 1); b++) step();
    check_val("t5_setup_val", out_val, 1'b1);
    check_val("t5_setup_src", out_src, 2);
    do_reset();
    check_val("t5_out_val", out_val, 1'b0);
    check_val("t5_count", count, 0);
    src_log.delete();
    repeat (4) step();
    check_val("t5_first", (src_log.size() > 0) ? src_log[0] : 99, 0);
    for (int b = 0; b < 100 && !all_idle(); b++) step();
    step();

    // Random-delay sources and random sink backpressure.
    maxd[0] = 0; maxd[1] = 1; maxd[2] = 2; maxd[3] = 10;
    c0 = int'(count);
    src_log.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 20; k++) enq(i, 8'(i * 64 + k));
    drive();
    done = 1'b0;
    for (int b = 0; b < 5000 && !done; b++) begin
      out_rdy = ($urandom_range(9, 0) < 7);
      step();
      done = all_idle();
    end
    check_val("t6_done", done, 1'b1);
    check_val("t6_count", count - 32'(c0), 80);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (src_log[j]) if (src_log[j] >= 0 && src_log[j] < N) cnt[src_log[j]]++;
    for (int i = 0; i < N; i++) check_val("t6_per_src", cnt[i], 20);

    repeat (2) step();
    check_val("n3_finished", n3_done, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Three requesters under full contention: pointer must wrap 2 -> 0.
  initial begin
    int k;
    int cyc;
    reset3 = 1'b0;
    out_rdy3 = 1'b1;
    in_val3 = 3'b111;
    in_msg3 = {8'h20, 8'h10, 8'h00};
    repeat (2) begin
      @(negedge clk);
      check_val("n3_rdy_rst", in_rdy3, 3'b000);
    end
    @(posedge clk);
    #1 reset3 = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 7 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (out_val3) begin
        check_val("n3_src", out_src3, k % 3);
        check_val("n3_msg", out_msg3, 8'h10 * (k % 3));
        k++;
      end
    end
    check_val("n3_nout", k, 7);
    n3_done = 1'b1;
  end

endmodule
